// File: rtl/init_i2c_axil_pkg.sv
// Shared response codes and FSM state types for the init_i2c_axil register slave.
package init_i2c_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HALF,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } rd_state_t;

endpackage

// File: rtl/init_i2c_axil_regfile.sv
// Byte-strobed 32-bit register array with a flattened view of every register.
module init_i2c_axil_regfile #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  output logic [32*NUM_REGS-1:0] o_regs
);

  logic [31:0] r_mem [NUM_REGS];

  // NOTE: every word is reset because the flattened contents are visible at the
  // ports and must read zero after reset; a plain RAM macro cannot be used here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_regs[32*k +: 32] = r_mem[k];
  end

endmodule

// File: rtl/init_i2c_axil_slave.sv
// AXI4-Lite register slave: independent AW/W capture, registered B and R channels.
// Define INIT_I2C_AXIL_WRCNT_EN to expose a read-only count of OKAY writes at index NUM_REGS.
module init_i2c_axil_slave
  import init_i2c_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 16,
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [31:0]            S_AXI_WDATA,
  input  logic [3:0]             S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [31:0]            S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0] REG_O,
  output logic                   WR_PULSE_O,
  output logic [IDX_W-1:0]       WR_IDX_O
);

  localparam int          IW    = ADDR_WIDTH - 2;
  localparam int unsigned NREGS = NUM_REGS;

  wr_state_t        r_wr_state;
  logic             r_aw_latched, r_w_latched;
  logic [IW-1:0]    r_aw_idx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_awready, r_wready, r_bvalid, r_wr_pulse;
  logic [1:0]       r_bresp;
  logic [IDX_W-1:0] r_wr_idx;

  rd_state_t        r_rd_state;
  logic             r_arready, r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic             w_aw_hs, w_w_hs, w_have_aw, w_have_w, w_commit, w_wr_ok;
  logic [IW-1:0]    w_wr_idx;
  logic [31:0]      w_wr_data;
  logic [3:0]       w_wr_strb;
  logic             w_ar_hs;
  logic [IW-1:0]    w_rd_idx;
  logic [31:0]      w_rd_data;
  logic [1:0]       w_rd_resp;
  logic             w_unused;

  assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A half-latched write combines the stored half with whatever arrives this cycle.
  assign w_aw_hs   = S_AXI_AWVALID && r_awready;
  assign w_w_hs    = S_AXI_WVALID && r_wready;
  assign w_have_aw = r_aw_latched || w_aw_hs;
  assign w_have_w  = r_w_latched || w_w_hs;
  assign w_commit  = (r_wr_state != W_RESP) && w_have_aw && w_have_w;
  assign w_wr_idx  = r_aw_latched ? r_aw_idx : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign w_wr_data = r_w_latched ? r_wdata : S_AXI_WDATA;
  assign w_wr_strb = r_w_latched ? r_wstrb : S_AXI_WSTRB;
  assign w_wr_ok   = 32'(w_wr_idx) < NREGS;

  init_i2c_axil_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_we    (w_commit && w_wr_ok),
    .i_idx   (w_wr_idx[IDX_W-1:0]),
    .i_wdata (w_wr_data),
    .i_wstrb (w_wr_strb),
    .o_regs  (REG_O)
  );

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples the pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_state   <= W_IDLE;
      r_aw_latched <= 1'b0;
      r_w_latched  <= 1'b0;
      r_aw_idx     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_wr_pulse   <= 1'b0;
      r_wr_idx     <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      case (r_wr_state)
        W_IDLE, W_HALF: begin
          if (w_commit) begin
            r_wr_state   <= W_RESP;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b1;
            r_bresp      <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            r_wr_pulse   <= w_wr_ok;
            if (w_wr_ok) r_wr_idx <= w_wr_idx[IDX_W-1:0];
          end else begin
            if (w_aw_hs) begin
              r_aw_latched <= 1'b1;
              r_aw_idx     <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
              r_w_latched <= 1'b1;
              r_wdata     <= S_AXI_WDATA;
              r_wstrb     <= S_AXI_WSTRB;
            end
            r_awready  <= !w_have_aw;
            r_wready   <= !w_have_w;
            r_wr_state <= (w_have_aw || w_have_w) ? W_HALF : W_IDLE;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

`ifdef INIT_I2C_AXIL_WRCNT_EN
  logic [31:0] r_wr_cnt;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                  r_wr_cnt <= '0;
    else if (w_commit && w_wr_ok) r_wr_cnt <= r_wr_cnt + 32'd1;
  end
`endif

  assign w_ar_hs  = S_AXI_ARVALID && r_arready;
  assign w_rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  // NOTE: defaults come first so no path through the mux leaves an output unassigned.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_SLVERR;
    if (32'(w_rd_idx) < NREGS) begin
      w_rd_data = REG_O[{w_rd_idx[IDX_W-1:0], 5'b0} +: 32];
      w_rd_resp = RESP_OKAY;
    end
`ifdef INIT_I2C_AXIL_WRCNT_EN
    if (32'(w_rd_idx) == NREGS) begin
      w_rd_data = r_wr_cnt;
      w_rd_resp = RESP_OKAY;
    end
`endif
  end

  // RDATA is captured from REG_O before this edge's write lands, so a colliding read sees the old value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rd_state <= R_VALID;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_resp;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_VALID: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign WR_PULSE_O    = r_wr_pulse;
  assign WR_IDX_O      = r_wr_idx;

endmodule

// File: doc/init_i2c_axil_slave.md
INIT_I2C_AXIL_SLAVE -- requirements
Module: init_i2c_axil_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: AXI4-Lite byte-address width.
REQ-002 Parameter NUM_REGS, default 16: number of 32-bit registers; SHALL satisfy NUM_REGS*4 <= 2**ADDR_WIDTH.
REQ-003 ACLK  in  1  sole clock; all logic on the rising edge.
REQ-004 ARESET  in  1  reset, asynchronous, active-high.
REQ-005 S_AXI_AWADDR  in  ADDR_WIDTH  write address; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-006 S_AXI_WDATA  in  32  write data; S_AXI_WSTRB in 4 byte enables; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-007 S_AXI_BRESP  out  2  write response; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-008 S_AXI_ARADDR  in  ADDR_WIDTH  read address; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-009 S_AXI_RDATA  out  32  read data; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-010 REG_O  out  32*NUM_REGS  flattened register contents; register k is REG_O[32k+31:32k].
REQ-011 WR_PULSE_O  out  1  one-cycle pulse on each committed register write; WR_IDX_O out $clog2(NUM_REGS) index of that register.

Function
REQ-012 Register index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] SHALL be ignored.
REQ-013 AW and W SHALL be captured independently: AWREADY=1 while no address is latched and no B is pending; WREADY=1 while no data is latched and no B is pending.
REQ-014 Write FSM states: W_IDLE -> W_HALF (one of AW/W latched) -> W_RESP; an AW and W handshake in the same cycle SHALL go directly W_IDLE -> W_RESP.
REQ-015 On entry to W_RESP the write SHALL commit: each byte lane i with WSTRB[i]=1 updated; REG_O updated in the same cycle BVALID rises.
REQ-016 Latency: BVALID SHALL assert the cycle after the later of the AW and W handshakes; BVALID and BRESP SHALL hold until BVALID&&BREADY, then return to W_IDLE.
REQ-017 Index >= NUM_REGS: no register changes, no WR_PULSE_O, BRESP=2'b10 (SLVERR); otherwise BRESP=2'b00.
REQ-018 WSTRB=4'b0000 to a valid index: BRESP OKAY, no data change, WR_PULSE_O still pulses.
REQ-019 Read FSM states R_IDLE -> R_VALID: ARREADY=1 only in R_IDLE; RVALID, RDATA and RRESP SHALL be registered and asserted the cycle after the AR handshake, then held until RVALID&&RREADY.
REQ-020 Out-of-range read: RDATA=0, RRESP=2'b10.
REQ-021 Read and write commit to the same register in the same cycle: RDATA SHALL return the pre-write value.
REQ-022 The read and write channels SHALL operate concurrently without mutual stalls.

Reset
REQ-023 On ARESET: all registers 0; AWREADY, WREADY, ARREADY, BVALID, RVALID, WR_PULSE_O = 0; BRESP, RRESP, RDATA, WR_IDX_O = 0; both FSMs to idle.
REQ-024 ARESET mid-transaction SHALL drop any partial latch or pending response without committing it; READY outputs SHALL rise the first cycle after release.

Configuration
REQ-025 Macro INIT_I2C_AXIL_WRCNT_EN defined: index NUM_REGS is a read-only 32-bit counter of committed OKAY writes (wraps at 2**32-1 -> 0); writes to it return SLVERR; reset value 0.
REQ-026 Macro undefined: no counter; index NUM_REGS behaves as out of range (REQ-017, REQ-020).

Structure
REQ-027 Package init_i2c_axil_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants and the write/read FSM state enums.
REQ-028 Sub-module init_i2c_axil_regfile SHALL hold the byte-strobed register array and the REG_O mapping; AXI handshake logic remains in the top module.

Verification
REQ-029 AW and W in the same cycle: addr 0x04, data 0xDEADBEEF, strb 0xF -> BVALID next cycle, BRESP=0, REG_O[63:32]=0xDEADBEEF, WR_PULSE_O with WR_IDX_O=1.
REQ-030 W 3 cycles before AW (addr 0x08, data 0x12345678, strb 0x3), BREADY held low 4 cycles -> register 2 = 0x00005678, BVALID held stable until BREADY.
REQ-031 Write to 0x3C then read 0x3C: read returns the written data with RRESP=0; read 0x40 with NUM_REGS=16 -> RDATA=0, RRESP=2'b10 (0x40 requires ADDR_WIDTH >= 7; with the default ADDR_WIDTH=6, build this scenario at ADDR_WIDTH=7).
REQ-032 Write 0xAAAAAAAA to reg 3 concurrently with an AR to reg 3 holding 0x11111111 -> RDATA=0x11111111; a later read returns 0xAAAAAAAA.
REQ-033 ARESET asserted while AW is latched and W is pending -> no commit, all outputs 0; after release a full write completes normally.
REQ-034 With INIT_I2C_AXIL_WRCNT_EN defined: 5 OKAY writes and 1 SLVERR write, then read 0x40 -> RDATA=5 (0x40 requires ADDR_WIDTH >= 7; build this scenario at ADDR_WIDTH=7).
